// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60), colour type and the test-bar palette.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HSYNC_START = H_ACTIVE + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int VSYNC_START = V_ACTIVE + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Bar n lights R/G/B from bits 2/1/0 of n.
    localparam rgb_t TEST_BAR_RGB [8] = '{
        12'h000, 12'h00F, 12'h0F0, 12'h0FF,
        12'hF00, 12'hF0F, 12'hFF0, 12'hFFF
    };

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of configurable width and depth; depth 0 is a plain wire.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH > 0) begin : g_taps
        logic [WIDTH-1:0] tap_reg [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    tap_reg[i] <= RST_VAL;
                end
            end else if (en) begin
                tap_reg[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    tap_reg[i] <= tap_reg[i-1];
                end
            end
        end

        assign dout = tap_reg[DEPTH-1];
    end else begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, en};
        assign dout       = din;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing, pixel-pipeline alignment and registered VGA pins.
// Optional macro VGA_TEST_PATTERN_EN replaces rgb_in with eight vertical colour bars.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int PIPE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        line_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG      = H_ACTIVE + H_FP;
    localparam int HS_END      = HS_BEG + H_SYNC - 1;
    localparam int VS_BEG      = V_ACTIVE + V_FP;
    localparam int VS_END      = VS_BEG + V_SYNC - 1;
    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick_reg;
    logic [9:0]       hcnt_reg, hcnt_next;
    logic [9:0]       vcnt_reg, vcnt_next;
    logic             active, hs_raw, vs_raw;
    logic             act_d, hs_d, vs_d;
    logic             hs_reg, vs_reg;
    rgb_t             pix_rgb, rgb_reg;

    // tick_reg is registered from div_next so it is high exactly while div_reg sits at CLK_DIV-1.
    always_comb begin
        div_next = div_reg + 1'b1;
        if (div_reg == DIV_W'(CLK_DIV - 1)) begin
            div_next = '0;
        end
    end

    always_comb begin
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        if (tick_reg) begin
            if (hcnt_reg == 10'(LINE_LEN - 1)) begin
                hcnt_next = '0;
                vcnt_next = (vcnt_reg == 10'(FRAME_LINES - 1)) ? '0 : vcnt_reg + 10'd1;
            end else begin
                hcnt_next = hcnt_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else begin
            div_reg  <= div_next;
            tick_reg <= (div_next == DIV_W'(CLK_DIV - 1));
            hcnt_reg <= hcnt_next;
            vcnt_reg <= vcnt_next;
        end
    end

    assign active = (hcnt_reg < 10'(H_ACTIVE)) && (vcnt_reg < 10'(V_ACTIVE));
    assign hs_raw = !((hcnt_reg >= 10'(HS_BEG)) && (hcnt_reg <= 10'(HS_END)));
    assign vs_raw = !((vcnt_reg >= 10'(VS_BEG)) && (vcnt_reg <= 10'(VS_END)));

    assign pix_x       = active ? hcnt_reg : '0;
    assign pix_y       = active ? vcnt_reg[8:0] : '0;
    assign pix_tick    = tick_reg;
    assign line_start  = tick_reg && (hcnt_reg == '0);
    assign frame_start = line_start && (vcnt_reg == 10'(V_ACTIVE));

`ifdef VGA_TEST_PATTERN_EN
    localparam int PIPE_W = 6;
    localparam int BAR_W  = H_ACTIVE / 8;

    logic [7:1] bar_ge;
    logic [2:0] bar_raw, bar_d;

    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
        assign bar_ge[gi] = (hcnt_reg >= 10'(gi * BAR_W));
    end

    assign bar_raw = 3'($countones(bar_ge));
`else
    localparam int PIPE_W = 3;
`endif

    logic [PIPE_W-1:0] pipe_in, pipe_out;

`ifdef VGA_TEST_PATTERN_EN
    assign pipe_in                    = {bar_raw, active, hs_raw, vs_raw};
    assign {bar_d, act_d, hs_d, vs_d} = pipe_out;
`else
    assign pipe_in             = {active, hs_raw, vs_raw};
    assign {act_d, hs_d, vs_d} = pipe_out;
`endif

    // Reset value parks the syncs high and blanks the pixel.
    vga_delay_line #(
        .WIDTH   (PIPE_W),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (PIPE_W'(3))
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_reg),
        .din  (pipe_in),
        .dout (pipe_out)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic unused_rgb_in;
    assign unused_rgb_in = ^rgb_in;
    assign pix_rgb       = TEST_BAR_RGB[bar_d];
`else
    assign pix_rgb = rgb_t'(rgb_in);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_reg  <= 1'b1;
            vs_reg  <= 1'b1;
            rgb_reg <= '0;
        end else if (tick_reg) begin
            hs_reg  <= hs_d;
            vs_reg  <= vs_d;
            rgb_reg <= act_d ? pix_rgb : '0;
        end
    end

    assign vga_hs = hs_reg;
    assign vga_vs = vs_reg;
    assign vga_r  = rgb_reg.r;
    assign vga_g  = rgb_reg.g;
    assign vga_b  = rgb_reg.b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench: three instances with reduced raster sizes and different divider/latency.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 6,  VF = 2, VSY = 2, VB = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int ND = 3;
    localparam int HIST = 65536;
    localparam int DIVS [ND] = '{4, 1, 2};
    localparam int LATS [ND] = '{1, 0, 3};

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        tick;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    localparam exp_t RST_EXP = '{10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rgb_in      [ND];
    logic [9:0]  pix_x       [ND];
    logic [8:0]  pix_y       [ND];
    logic        pix_tick    [ND];
    logic        frame_start [ND];
    logic        line_start  [ND];
    logic        vga_hs      [ND];
    logic        vga_vs      [ND];
    logic [3:0]  vga_r       [ND];
    logic [3:0]  vga_g       [ND];
    logic [3:0]  vga_b       [ND];

    int          total = 0;
    int          bad   = 0;
    int          n;
    int          k        [ND];
    bit          tick_now [ND];
    int          mode;
    logic [11:0] rgb_hist [ND][HIST];

    always #5 clk = ~clk;

    vga_timing_ctrl #(.CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIPE_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .rgb_in(rgb_in[0]), .pix_x(pix_x[0]), .pix_y(pix_y[0]),
        .pix_tick(pix_tick[0]), .frame_start(frame_start[0]), .line_start(line_start[0]),
        .vga_hs(vga_hs[0]), .vga_vs(vga_vs[0]), .vga_r(vga_r[0]), .vga_g(vga_g[0]), .vga_b(vga_b[0]));

    vga_timing_ctrl #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIPE_LAT(0)) u_dut1 (
        .clk(clk), .rst(rst), .rgb_in(rgb_in[1]), .pix_x(pix_x[1]), .pix_y(pix_y[1]),
        .pix_tick(pix_tick[1]), .frame_start(frame_start[1]), .line_start(line_start[1]),
        .vga_hs(vga_hs[1]), .vga_vs(vga_vs[1]), .vga_r(vga_r[1]), .vga_g(vga_g[1]), .vga_b(vga_b[1]));

    vga_timing_ctrl #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIPE_LAT(3)) u_dut2 (
        .clk(clk), .rst(rst), .rgb_in(rgb_in[2]), .pix_x(pix_x[2]), .pix_y(pix_y[2]),
        .pix_tick(pix_tick[2]), .frame_start(frame_start[2]), .line_start(line_start[2]),
        .vga_hs(vga_hs[2]), .vga_vs(vga_vs[2]), .vga_r(vga_r[2]), .vga_g(vga_g[2]), .vga_b(vga_b[2]));

    // Raster position of pixel tick t counted from reset release.
    function automatic int ph(input int t);
        return t % HT;
    endfunction

    function automatic int pv(input int t);
        return (t / HT) % VT;
    endfunction

    function automatic bit vis(input int t);
        return (t >= 0) && (ph(t) < HA) && (pv(t) < VA);
    endfunction

    function automatic bit hs_lo(input int t);
        return (t >= 0) && (ph(t) >= HA + HF) && (ph(t) < HA + HF + HSY);
    endfunction

    function automatic bit vs_lo(input int t);
        return (t >= 0) && (pv(t) >= VA + VF) && (pv(t) < VA + VF + VSY);
    endfunction

    function automatic logic [11:0] bar_rgb(input int h);
        logic [2:0] b;
        b = 3'(h / (HA / 8));
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    endfunction

    // Generator model: rgb for tick t carries the low bits of the x shown LAT ticks earlier.
    function automatic logic [11:0] gen_rgb(input int d);
        int         q;
        logic [3:0] xr;
        q  = k[d] - LATS[d];
        xr = vis(q) ? 4'(ph(q)) : 4'h0;
        if (mode == 1) return 12'hABC;
        return {xr, 8'($urandom)};
    endfunction

    // Expected outputs: counters show tick k; pins show the capture made at tick k-1.
    function automatic exp_t model(input int d);
        exp_t e;
        int   t, j, p;
        t      = k[d];
        j      = t - 1;
        p      = j - LATS[d];
        e.tick = tick_now[d];
        e.x    = vis(t) ? 10'(ph(t)) : 10'd0;
        e.y    = vis(t) ? 9'(pv(t)) : 9'd0;
        e.ls   = tick_now[d] && (ph(t) == 0);
        e.fs   = e.ls && (pv(t) == VA);
        e.hs   = !hs_lo(p);
        e.vs   = !vs_lo(p);
        if (j < 0 || !vis(p)) begin
            e.rgb = 12'h000;
        end else begin
`ifdef VGA_TEST_PATTERN_EN
            e.rgb = bar_rgb(ph(p));
`else
            e.rgb = rgb_hist[d][j % HIST];
`endif
        end
        return e;
    endfunction

    function automatic exp_t observe(input int d);
        exp_t o;
        o.x    = pix_x[d];
        o.y    = pix_y[d];
        o.tick = pix_tick[d];
        o.ls   = line_start[d];
        o.fs   = frame_start[d];
        o.hs   = vga_hs[d];
        o.vs   = vga_vs[d];
        o.rgb  = {vga_r[d], vga_g[d], vga_b[d]};
        return o;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int d = 0; d < ND; d++) begin
            k[d]        = 0;
            tick_now[d] = 1'b0;
        end
    endtask

    // One clock: retire ticks at the posedge, then at the negedge decide the next tick and drive rgb_in.
    task automatic advance();
        logic [11:0] v;
        @(posedge clk);
        if (!rst) begin
            n++;
            for (int d = 0; d < ND; d++) if (tick_now[d]) k[d]++;
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            tick_now[d] = !rst && (n >= 1) && ((n % DIVS[d]) == DIVS[d] - 1);
            if (tick_now[d]) begin
                v                       = gen_rgb(d);
                rgb_hist[d][k[d] % HIST] = v;
                rgb_in[d]               = v;
            end else begin
                rgb_in[d] = 12'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst  = 1'b1;
        mode = 0;
        model_reset();
        for (int d = 0; d < ND; d++) rgb_in[d] = 12'hFFF;
        repeat (4) begin
            advance();
            for (int d = 0; d < ND; d++) begin
                e = model(d);
                o = observe(d);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL reset dut%0d got=%h want=%h", d, o, e);
                end
            end
        end
        rst = 1'b0;
        $display("test_reset: released at %0t", $time);
    endtask

    task automatic test_timing(input int ncyc);
        exp_t e, o;
        int   last_ls, last_fs, hs_run, vs_run;
        logic hs_prev, vs_prev;
        last_ls = -1; last_fs = -1; hs_run = 0; vs_run = 0;
        hs_prev = 1'b1; vs_prev = 1'b1;
        mode    = 0;
        for (int c = 0; c < ncyc; c++) begin
            advance();
            for (int d = 0; d < ND; d++) begin
                e = model(d);
                o = observe(d);
                total++;
                if ({o.x, o.y, o.tick, o.ls, o.fs} !== {e.x, e.y, e.tick, e.ls, e.fs}) begin
                    bad++;
                    $display("FAIL timing_cnt dut%0d n=%0d got x=%0d y=%0d t=%b ls=%b fs=%b want x=%0d y=%0d t=%b ls=%b fs=%b",
                             d, n, o.x, o.y, o.tick, o.ls, o.fs, e.x, e.y, e.tick, e.ls, e.fs);
                end
                total++;
                if ({o.hs, o.vs, o.rgb} !== {e.hs, e.vs, e.rgb}) begin
                    bad++;
                    $display("FAIL timing_pins dut%0d n=%0d got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                             d, n, o.hs, o.vs, o.rgb, e.hs, e.vs, e.rgb);
                end
            end
            if (tick_now[0]) begin
                if (line_start[0] === 1'b1) last_ls = k[0];
                if (frame_start[0] === 1'b1) begin
                    if (last_fs >= 0) begin
                        total++;
                        if (k[0] - last_fs != HT * VT) begin
                            bad++;
                            $display("FAIL frame_period got=%0d want=%0d", k[0] - last_fs, HT * VT);
                        end
                    end
                    last_fs = k[0];
                    $display("test_timing: frame_start at tick %0d", k[0]);
                end
                if (vga_hs[0] === 1'b0 && hs_prev && last_ls >= 0) begin
                    total++;
                    if (k[0] - last_ls != HA + HF + LATS[0] + 1) begin
                        bad++;
                        $display("FAIL hs_offset got=%0d want=%0d", k[0] - last_ls, HA + HF + LATS[0] + 1);
                    end
                end
                if (vga_hs[0] === 1'b1 && !hs_prev) begin
                    total++;
                    if (hs_run != HSY) begin
                        bad++;
                        $display("FAIL hs_width got=%0d want=%0d", hs_run, HSY);
                    end
                end
                if (vga_vs[0] === 1'b0 && vs_prev && last_fs >= 0) begin
                    total++;
                    if (k[0] - last_fs != VF * HT + LATS[0] + 1) begin
                        bad++;
                        $display("FAIL vs_offset got=%0d want=%0d", k[0] - last_fs, VF * HT + LATS[0] + 1);
                    end
                end
                if (vga_vs[0] === 1'b1 && !vs_prev) begin
                    total++;
                    if (vs_run != VSY * HT) begin
                        bad++;
                        $display("FAIL vs_width got=%0d want=%0d", vs_run, VSY * HT);
                    end
                end
                hs_run  = (vga_hs[0] === 1'b1) ? 0 : hs_run + 1;
                vs_run  = (vga_vs[0] === 1'b1) ? 0 : vs_run + 1;
                hs_prev = vga_hs[0];
                vs_prev = vga_vs[0];
            end
        end
    endtask

    task automatic test_colour(input int ncyc);
        exp_t e, o;
        int   lit;
        mode = 1;
        lit  = 0;
        for (int c = 0; c < ncyc; c++) begin
            advance();
            for (int d = 0; d < ND; d++) begin
                e = model(d);
                o = observe(d);
                total++;
                if ({o.hs, o.vs, o.rgb} !== {e.hs, e.vs, e.rgb}) begin
                    bad++;
                    $display("FAIL colour dut%0d n=%0d got rgb=%h hs=%b want rgb=%h hs=%b",
                             d, n, o.rgb, o.hs, e.rgb, e.hs);
                end
                if (d == 0 && tick_now[0] && e.rgb != 12'h000) lit++;
            end
        end
        $display("test_colour: %0d coloured ticks checked on dut0", lit);
    endtask

    task automatic test_midframe_reset(input int ncyc);
        exp_t e, o;
        int   guard;
        bit   first;
        mode  = 0;
        guard = 0;
        while (!(pv(k[0]) == 3 && ph(k[0]) == 10) && guard < 4000) begin
            advance();
            guard++;
        end
        total++;
        if (guard >= 4000) begin
            bad++;
            $display("FAIL midframe_wait got=%0d cycles want<4000", guard);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            o = observe(d);
            total++;
            if (o !== RST_EXP) begin
                bad++;
                $display("FAIL async_reset dut%0d got=%h want=%h", d, o, RST_EXP);
            end
        end
        model_reset();
        repeat (3) begin
            advance();
            for (int d = 0; d < ND; d++) begin
                o = observe(d);
                total++;
                if (o !== RST_EXP) begin
                    bad++;
                    $display("FAIL reset_hold dut%0d got=%h want=%h", d, o, RST_EXP);
                end
            end
        end
        rst   = 1'b0;
        first = 1'b1;
        $display("test_midframe_reset: released at %0t", $time);
        for (int c = 0; c < ncyc; c++) begin
            advance();
            if (tick_now[0] && first) begin
                first = 1'b0;
                total++;
                if (!(line_start[0] === 1'b1 && pix_y[0] === 9'd0 && pix_x[0] === 10'd0)) begin
                    bad++;
                    $display("FAIL first_tick got ls=%b y=%0d x=%0d want ls=1 y=0 x=0",
                             line_start[0], pix_y[0], pix_x[0]);
                end
            end
            for (int d = 0; d < ND; d++) begin
                e = model(d);
                o = observe(d);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL post_reset dut%0d n=%0d got=%h want=%h", d, n, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing(2600);
        test_colour(1300);
        test_midframe_reset(1300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Display-side end of the pixel interface: generates 640x480@60 Hz VGA timing from the system clock and drives pix_x/pix_y to the pixel-colour generator.
- Accepts the generator's rgb back after a fixed pipeline latency and drives the registered VGA pins.
- Supplies frame and line strobes to game logic.
- Sits between the colour generator and the board's VGA connector.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz to 25 MHz); must be >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- PIPE_LAT, 1, pixel ticks from pix_x/pix_y to a valid rgb_in (block-ROM read latency); range 0..3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rgb_in  in  12  colour from the generator, {R[3:0],G[3:0],B[3:0]}
- pix_x  out  10  current visible column, 0..639
- pix_y  out  9  current visible row, 0..479
- pix_tick  out  1  one-clk pulse per pixel (clock enable)
- frame_start  out  1  one-pixel-tick pulse at h=0, v=V_ACTIVE (start of vertical blank)
- line_start  out  1  one-pixel-tick pulse at h=0 of every line
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue

Behaviour:
- Reset (async, active-high): clears the divider, hcnt, vcnt and all delay stages.
  - vga_hs=1, vga_vs=1, rgb pins=0.
  - pix_x=0, pix_y=0; pix_tick, frame_start and line_start=0.
- Divider counts 0..CLK_DIV-1. pix_tick=1 on the cycle where the divider is at CLK_DIV-1. With CLK_DIV=1, pix_tick is held at 1.
- hcnt (10 bit) counts 0..H_TOTAL-1 (799) on pix_tick and wraps to 0. vcnt (10 bit) increments when hcnt wraps and wraps at V_TOTAL-1 (524).
- active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- pix_x = hcnt when active, else 0. pix_y = vcnt[8:0] when active, else 0.
- Sync generation:
  - hs_raw low for hcnt in [656,751].
  - vs_raw low for vcnt in [490,491].
- Strobes line_start and frame_start are decoded from the counters and are undelayed. Each is high for the whole pix_tick-aligned clk cycle only.
- Alignment pipeline: active, hs_raw and vs_raw pass through PIPE_LAT shift stages, advanced only on pix_tick. This keeps them aligned with rgb_in.
- Output register (on pix_tick):
  - vga_hs, vga_vs = delayed syncs.
  - rgb pins = delayed active ? rgb_in : 0.
  - Total pin latency = PIPE_LAT+1 pixel ticks after pix_x/pix_y.
- Blanking always forces rgb pins to 0 regardless of rgb_in.
- Boundary conditions:
  - At hcnt=799 and vcnt=524, both counters wrap to 0 on the same tick.
  - rgb_in is sampled only on pix_tick; changes between ticks are ignored.
  - Reset asserted mid-frame restarts timing at h=0, v=0 with syncs deasserted. The first post-reset frame has full timing.
- Derived constants H_TOTAL=800, V_TOTAL=525 are computed from the parameters, not hard-coded.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined: rgb_in is ignored. Output colour is eight vertical bars, 80 pixels wide, indexed by the delayed x[9:7]-equivalent bar number 0..7:
  - colours 000, 00F, 0F0, 0FF, F00, F0F, FF0, FFF in order;
  - same pipeline latency;
  - blanking still forces 0.
- Undefined: normal pass-through of rgb_in.

Decomposition:
- Shared package vga_pkg:
  - timing constants H_ACTIVE..V_BP, H_TOTAL, V_TOTAL;
  - hsync/vsync start and end positions;
  - rgb_t typedef (12-bit packed struct of three 4-bit fields);
  - test-bar colour constant array.
- One sub-module, vga_delay_line: parameterised width and depth, clock-enabled shift register. Used for the active/hs/vs alignment, and depth 0 degenerates to a wire.

Test Plan:
- Reset then run one frame, CLK_DIV=4 → pix_tick every 4th clk; hcnt period 800 ticks (3200 clk); vga_hs low for exactly 96 ticks starting 656+PIPE_LAT+1 ticks after line_start.
- Full frame → vga_vs low for 2 lines (1600 ticks) starting at line 490 (delayed); frame_start pulses once per 420000 ticks, at v=480, h=0.
- Drive rgb_in=12'hABC constant → during active region pins r=A, g=B, b=C; during blanking (e.g. h=700) pins=0; first coloured pixel appears PIPE_LAT+1 ticks after pix_x=0.
- Loopback model: rgb_in = pix_x[3:0] delayed PIPE_LAT ticks → vga_r equals the x that was presented PIPE_LAT+1 ticks earlier for every active pixel, for PIPE_LAT=0,1,3.
- Assert rst at v=200, h=300 for 3 clk → outputs go to reset values immediately (asynchronously); after release, line_start at first tick and pix_y=0.
- With VGA_TEST_PATTERN_EN, line 10 → pins show 000 for x 0..79, 00F for x 80..159, …, FFF for x 560..639; 0 in blanking.
